uart_rx: RTL

- UART receiver, 8N1 by default, for the 100 MHz system clock domain.
- Receive-side counterpart of the existing baud clock divider and transmit path.
- Generates its own 16x-oversampled tick from clk, so it needs no baud clock input.
- Validates the start bit, samples each data bit mid-bit, checks the stop bit, and presents each byte with a one-cycle valid pulse to downstream logic (command parser, FIFO).

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_if.sv | 29 ++
 rtl/uart_baud_tick.sv | 43 ++++
 rtl/uart_rx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants, FSM state type and baud divider helper for the UART
// receive path. The transmitter can reuse the same divider function.
// Contents:
//   SYS_CLK_HZ          system clock frequency (Hz)
//   DEFAULT_BAUD        default line rate (Bd)
//   DEFAULT_OVERSAMPLE  default samples per bit
//   rx_state_t          receiver FSM states
//   calc_div()          clocks per oversample tick (integer truncation)
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int SYS_CLK_HZ         = 100_000_000;
    localparam int DEFAULT_BAUD       = 9600;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    function automatic int calc_div(input int sys_clk, input int baud, input int oversample);
        return sys_clk / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Serial line plus received-byte outputs of the UART receiver.
//   rx          serial line, idle high (driven by master)
//   data_out    last good byte
//   data_valid  one-cycle pulse, data_out valid
//   frame_err   one-cycle pulse, stop bit sampled low
//   busy        receiver not idle
//   parity_err  one-cycle pulse, only when UART_RX_PARITY_EN is defined
// Modports: master = line driver / byte consumer, slave = receiver.
// ----------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_err;

    modport master (output rx, input data_out, data_valid, frame_err, busy, parity_err);
    modport slave  (input rx, output data_out, data_valid, frame_err, busy, parity_err);
`else
    modport master (output rx, input data_out, data_valid, frame_err, busy);
    modport slave  (input rx, output data_out, data_valid, frame_err, busy);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// ----------------------------------------------------------------------------
// uart_baud_tick
// Free-running oversample tick generator: counts 0..DIV-1 and pulses tick_o
// for one cycle while the count equals DIV-1. clr_i restarts the count at 0
// so the tick phase can be aligned to an external event (e.g. a start edge).
// Ports:
//   clk     system clock
//   rst     asynchronous active-high reset
//   clr_i   synchronous counter clear
//   tick_o  one-cycle tick every DIV clocks
// ----------------------------------------------------------------------------
module uart_baud_tick #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// UART receiver, 8N1 by default. Double-synchronises rx, aligns a 16x
// oversample tick to the start edge, validates the start bit at mid-bit,
// samples data bits LSB first at mid-bit and checks the stop bit. A good
// frame updates data_out with a one-cycle data_valid pulse; a low stop bit
// gives a one-cycle frame_err pulse and leaves data_out untouched.
// Optional build macro: UART_RX_PARITY_EN adds an even parity bit between
// data and stop, plus the parity_err pulse (data_out still updated,
// data_valid suppressed on a parity error).
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   uart_rx_if.slave (rx in; data_out, data_valid, frame_err, busy
//         [, parity_err] out)
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLK    = SYS_CLK_HZ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter int DATA_BITS  = 8
) (
    input logic     clk,
    input logic     rst,
    uart_rx_if.slave bus
);
    localparam int DIV = calc_div(SYS_CLK, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] HALF_M1  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] FULL_M1  = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

`ifdef UART_RX_PARITY_EN
    localparam rx_state_t AFTER_DATA = ST_PARITY;
`else
    localparam rx_state_t AFTER_DATA = ST_STOP;
`endif

    // Two-flop synchroniser, both stages reset to the idle line level.
    logic rx_meta_q;
    logic rx_s_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    logic tick;
    logic tick_clr;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    rx_state_t            state_q,      state_d;
    logic [SW-1:0]        s_cnt_q,      s_cnt_d;
    logic [BW-1:0]        bit_idx_q,    bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,      shift_d;
    logic [DATA_BITS-1:0] data_out_q,   data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 frame_err_q,  frame_err_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit_q,    par_bit_d;
    logic                 parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        s_cnt_d      = s_cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        tick_clr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Restart the tick counter on the start edge so every later
                // sample lands at mid-bit.
                if (!rx_s_q) begin
                    state_d  = ST_START;
                    tick_clr = 1'b1;
                    s_cnt_d  = '0;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_cnt_q == HALF_M1) begin
                        s_cnt_d = '0;
                        if (rx_s_q) begin
                            state_d = ST_IDLE;      // glitch, not a real start
                        end else begin
                            state_d   = ST_DATA;
                            bit_idx_d = '0;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_cnt_q == FULL_M1) begin
                        s_cnt_d = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_idx_q == LAST_BIT) begin
                            state_d = AFTER_DATA;
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    if (s_cnt_q == FULL_M1) begin
                        s_cnt_d   = '0;
                        par_bit_d = rx_s_q;
                        state_d   = ST_STOP;
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is seen.
                if (tick) begin
                    if (s_cnt_q == FULL_M1) begin
                        s_cnt_d = '0;
                        state_d = ST_IDLE;
                        if (rx_s_q) begin
                            data_out_d = shift_q;
`ifdef UART_RX_PARITY_EN
                            if ((^shift_q) ^ par_bit_q) begin
                                parity_err_d = 1'b1;
                            end else begin
                                data_valid_d = 1'b1;
                            end
`else
                            data_valid_d = 1'b1;
`endif
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            s_cnt_q      <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            s_cnt_q      <= s_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.busy       = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err = parity_err_q;
`endif

endmodule
